// File: rtl/fetch_queue_ctrl_pkg.sv
// Shared types and constants for the bf8b instruction-fetch queue controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 16;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Bundle of memory, shift-register, decoder and redirect signals of the fetch queue.
// Handshakes: mem_req/mem_addr held until mem_ack; instr moves when instr_valid && instr_ready.
interface fetch_queue_ctrl_if #(
  parameter int DEPTH  = fetch_pkg::DEF_DEPTH,
  parameter int WIDTH  = fetch_pkg::DEF_WIDTH,
  parameter int ADDR_W = fetch_pkg::DEF_ADDR_W
) ();
  import fetch_pkg::*;

  localparam int CW = count_w(DEPTH);

  logic                   mem_req;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_ack;
  logic [WIDTH-1:0]       mem_rdata;
  logic [DEPTH-1:0]       sr_en;
  logic [WIDTH-1:0]       sr_d;
  logic [DEPTH*WIDTH-1:0] sr_q_packed;
  logic [WIDTH-1:0]       instr;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   redirect;
  logic [ADDR_W-1:0]      redirect_pc;
  logic [CW-1:0]          count;
  state_t                 dbg_state;

  modport master (
    output mem_req, mem_addr, sr_en, sr_d, instr, instr_valid, count, dbg_state,
    input  mem_ack, mem_rdata, sr_q_packed, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, sr_en, sr_d, instr, instr_valid, count, dbg_state,
    output mem_ack, mem_rdata, sr_q_packed, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_queue_ctrl_queue_en_decode.sv
// Per-word shift enables for the external shift register and oldest-word select.
module queue_en_decode
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic [count_w(DEPTH)-1:0]              i_count,
  input  logic                                   i_push,
  input  logic                                   i_pop,
  output logic [DEPTH-1:0]                       o_sr_en,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] o_sel
);
  localparam int CW = count_w(DEPTH);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // A simultaneous pop lets the new word overwrite the oldest slot instead of growing.
  always_comb begin
    o_sr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_push) begin
        o_sr_en[i] = i_pop ? (CW'(i) < i_count) : (CW'(i) <= i_count);
      end
    end
  end

  assign o_sel = SW'(i_count - CW'(1));

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Instruction-fetch front end: fetches bytes over req/ack into an external shift register.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards mem_rdata straight to the decoder when empty.
module fetch_queue_ctrl
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                WIDTH    = DEF_WIDTH,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst,
  fetch_queue_ctrl_if.master bus
);
  localparam int CW = count_w(DEPTH);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drop_addr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              w_full;
  logic              w_ack_wait;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_sr_en;
  logic [SW-1:0]     w_sel;
  logic [WIDTH-1:0]  w_oldest;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_ack_wait = bus.mem_ack && (r_state == WAIT) && !bus.redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_ack_wait && (r_count == '0) && bus.instr_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_ack_wait && !w_bypass;
  assign w_pop  = (r_count != '0) && bus.instr_ready && !bus.redirect;

  queue_en_decode #(.DEPTH(DEPTH)) u_en_decode (
    .i_count (r_count),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .o_sr_en (w_sr_en),
    .o_sel   (w_sel)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (bus.redirect)        w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (!bus.redirect && !w_full) w_state_nxt = WAIT;
      WAIT: begin
        if (bus.redirect)      w_state_nxt = bus.mem_ack ? IDLE : DROP;
        else if (bus.mem_ack)  w_state_nxt = (w_count_nxt < CW'(DEPTH)) ? WAIT : IDLE;
      end
      DROP: if (bus.mem_ack && !bus.redirect) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (bus.redirect)    r_pc <= bus.redirect_pc;
      else if (w_ack_wait) r_pc <= r_pc + ADDR_W'(1);
      // The abandoned request keeps its address while pc already points at the new target.
      if (r_state == WAIT && w_state_nxt == DROP) r_drop_addr <= r_pc;
    end
  end

  assign w_oldest = bus.sr_q_packed[WIDTH*w_sel +: WIDTH];

  assign bus.mem_req     = (r_state != IDLE);
  assign bus.mem_addr    = (r_state == DROP) ? r_drop_addr : r_pc;
  assign bus.sr_en       = w_sr_en;
  assign bus.sr_d        = bus.mem_rdata;
  assign bus.instr       = w_bypass ? bus.mem_rdata : w_oldest;
  assign bus.instr_valid = (r_count != '0) || w_bypass;
  assign bus.count       = r_count;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Bench for fetch_queue_ctrl: behavioural shift register and memory, decode vector table,
// directed corner sequences and a random phase checked against an expected-byte queue.
module tb_fetch_queue_ctrl;
  import fetch_pkg::*;

  localparam int DEPTH  = 8;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 16;
  localparam int CW     = count_w(DEPTH);
  localparam int SW     = $clog2(DEPTH);

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  fetch_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stand-alone decode instance for the vector table
  logic [CW-1:0]    d_count;
  logic             d_push;
  logic             d_pop;
  logic [DEPTH-1:0] d_en;
  logic [SW-1:0]    d_sel;

  queue_en_decode #(.DEPTH(DEPTH)) u_dec_chk (
    .i_count (d_count),
    .i_push  (d_push),
    .i_pop   (d_pop),
    .o_sr_en (d_en),
    .o_sel   (d_sel)
  );

  // external word-enabled shift register model
  logic [WIDTH-1:0] sr_word [DEPTH];
  always @(posedge clk) begin
    if (bus.sr_en[0]) sr_word[0] <= bus.sr_d;
    for (int i = 1; i < DEPTH; i++) begin
      if (bus.sr_en[i]) sr_word[i] <= sr_word[i-1];
    end
  end
  always_comb begin
    bus.sr_q_packed = '0;
    for (int i = 0; i < DEPTH; i++) bus.sr_q_packed[WIDTH*i +: WIDTH] = sr_word[i];
  end

  // scoreboard state
  logic [WIDTH-1:0]  exp_q[$];
  logic [ADDR_W-1:0] exp_pc;
  logic              drop_pending;
  logic [DEPTH-1:0]  last_en;
  int                total;
  int                bad;

  typedef struct {
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] en;
    logic [SW-1:0]    sel;
  } dec_vec_t;
  dec_vec_t vecs [9];

  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    case (a)
      16'h0000: return 8'h2B;
      16'h0001: return 8'h2D;
      16'h0002: return 8'h3E;
      default:  return 8'(a * 7 + 1);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational/registered outputs 1ns later.
  // mode 0 = no ack, 1 = ack with memory contents, 2 = ack with data.
  task automatic cyc(input logic rdy, input logic redir, input logic [ADDR_W-1:0] rpc,
                     input int mode, input logic [WIDTH-1:0] data);
    logic             accepted;
    logic             exp_valid;
    logic [WIDTH-1:0] d;
    @(negedge clk);
    bus.instr_ready = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.mem_ack     = (mode != 0) && bus.mem_req;
    d               = (mode == 2) ? data : mem_byte(bus.mem_addr);
    bus.mem_rdata   = d;
    #1;
    last_en = bus.sr_en;
    check("count", 32'(bus.count), exp_q.size());
    accepted = bus.mem_ack && !drop_pending && !redir;
    if (bus.mem_ack && !drop_pending) check("mem_addr", 32'(bus.mem_addr), 32'(exp_pc));
    exp_valid = (exp_q.size() != 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    if (exp_q.size() == 0 && accepted && rdy) exp_valid = 1'b1;
`endif
    check("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
    if (accepted) begin
      total++;
      if (exp_q.size() >= DEPTH) begin
        bad++;
        $display("FAIL full_push: push with %0d queued, limit %0d", exp_q.size(), DEPTH);
      end
      exp_q.push_back(d);
      exp_pc = exp_pc + 16'd1;
    end
    if (bus.instr_valid && rdy && !redir) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL underflow: instr %0h popped with nothing expected", bus.instr);
      end else begin
        check("instr", 32'(bus.instr), 32'(exp_q.pop_front()));
      end
    end
    if (redir) begin
      if (bus.mem_req && !bus.mem_ack) drop_pending = 1'b1;
      exp_q.delete();
      exp_pc = rpc;
    end else if (bus.mem_ack && drop_pending) begin
      drop_pending = 1'b0;
    end
  endtask

  logic [WIDTH-1:0]  got_i[$];
  logic [ADDR_W-1:0] got_a[$];
  logic [ADDR_W-1:0] old_addr;
  int                guard;

  initial begin
    total = 0;
    bad = 0;
    drop_pending = 1'b0;
    exp_pc = 16'h0000;
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;

    // decode vector table
    vecs[0] = '{4'd0, 1'b1, 1'b0, 8'h01, 3'd0};
    vecs[1] = '{4'd3, 1'b1, 1'b0, 8'h0F, 3'd2};
    vecs[2] = '{4'd3, 1'b1, 1'b1, 8'h07, 3'd2};
    vecs[3] = '{4'd3, 1'b0, 1'b1, 8'h00, 3'd2};
    vecs[4] = '{4'd7, 1'b1, 1'b0, 8'hFF, 3'd6};
    vecs[5] = '{4'd8, 1'b1, 1'b1, 8'hFF, 3'd7};
    vecs[6] = '{4'd1, 1'b1, 1'b1, 8'h01, 3'd0};
    vecs[7] = '{4'd5, 1'b0, 1'b0, 8'h00, 3'd4};
    vecs[8] = '{4'd8, 1'b0, 1'b1, 8'h00, 3'd7};
    for (int v = 0; v < 9; v++) begin
      d_count = vecs[v].count;
      d_push  = vecs[v].push;
      d_pop   = vecs[v].pop;
      #1;
      check($sformatf("dec_en[%0d]", v), 32'(d_en), 32'(vecs[v].en));
      if (vecs[v].count != 0) check($sformatf("dec_sel[%0d]", v), 32'(d_sel), 32'(vecs[v].sel));
    end

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_instr_valid", 32'(bus.instr_valid), 0);
    check("rst_sr_en", 32'(bus.sr_en), 0);
    check("rst_count", 32'(bus.count), 0);
    rst = 1'b0;

    // zero-wait stream with ready high
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, '0, 1, '0);
      if (bus.instr_valid) got_i.push_back(bus.instr);
      if (bus.mem_ack) got_a.push_back(bus.mem_addr);
    end
    check("stream_len", got_i.size(), 3);
    if (got_i.size() == 3) begin
      check("stream0", 32'(got_i[0]), 32'h2B);
      check("stream1", 32'(got_i[1]), 32'h2D);
      check("stream2", 32'(got_i[2]), 32'h3E);
    end
    check("addr_len", got_a.size(), 4);
    if (got_a.size() == 4) begin
      check("addr0", 32'(got_a[0]), 0);
      check("addr1", 32'(got_a[1]), 1);
      check("addr2", 32'(got_a[2]), 2);
    end

    // fill to full with decoder stalled
    repeat (12) cyc(1'b0, 1'b0, '0, 1, '0);
    check("full_count", 32'(bus.count), DEPTH);
    check("full_no_req", 32'(bus.mem_req), 0);
    cyc(1'b1, 1'b0, '0, 1, '0);
    check("resume_a_req", 32'(bus.mem_req), 0);
    cyc(1'b1, 1'b0, '0, 1, '0);
    check("resume_b_count", 32'(bus.count), DEPTH - 1);
    check("resume_b_req", 32'(bus.mem_req), 0);
    cyc(1'b1, 1'b0, '0, 1, '0);
    check("resume_c_req", 32'(bus.mem_req), 1);

    // simultaneous push and pop at count 3
    guard = 0;
    while (exp_q.size() > 3 && guard < 20) begin
      cyc(1'b1, 1'b0, '0, 0, '0);
      guard++;
    end
    check("drain_to_3", exp_q.size(), 3);
    cyc(1'b1, 1'b0, '0, 1, '0);
    check("pushpop_en", 32'(last_en), 32'h07);
    cyc(1'b0, 1'b0, '0, 0, '0);
    check("pushpop_count", 32'(bus.count), 3);

    // redirect while waiting, late ack discarded
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      cyc(1'b1, 1'b0, '0, 0, '0);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    old_addr = exp_pc;
    cyc(1'b1, 1'b1, 16'h0040, 0, '0);
    cyc(1'b1, 1'b0, '0, 0, '0);
    check("drop_addr_held", 32'(bus.mem_addr), 32'(old_addr));
    check("drop_req", 32'(bus.mem_req), 1);
    cyc(1'b1, 1'b0, '0, 2, 8'h5B);
    check("drop_ack_addr", 32'(bus.mem_addr), 32'(old_addr));
    check("drop_no_valid", 32'(bus.instr_valid), 0);
    cyc(1'b1, 1'b0, '0, 0, '0);
    check("drop_count", 32'(bus.count), 0);
    check("drop_idle_req", 32'(bus.mem_req), 0);
    cyc(1'b1, 1'b0, '0, 0, '0);
    check("redir_req", 32'(bus.mem_req), 1);
    check("redir_addr", 32'(bus.mem_addr), 32'h0040);

    // redirect in the ack cycle
    cyc(1'b1, 1'b1, 16'h0100, 1, '0);
    check("redir_ack_en", 32'(last_en), 0);
    cyc(1'b1, 1'b0, '0, 0, '0);
    check("redir_ack_count", 32'(bus.count), 0);
    check("redir_ack_idle", 32'(bus.mem_req), 0);
    cyc(1'b1, 1'b0, '0, 0, '0);
    check("redir_ack_req", 32'(bus.mem_req), 1);
    check("redir_ack_addr", 32'(bus.mem_addr), 32'h0100);

    // empty-queue ack with decoder ready
    cyc(1'b1, 1'b0, '0, 2, 8'h2E);
`ifdef FETCH_QUEUE_BYPASS_EN
    check("bypass_valid", 32'(bus.instr_valid), 1);
    check("bypass_instr", 32'(bus.instr), 32'h2E);
    check("bypass_en", 32'(last_en), 0);
    cyc(1'b1, 1'b0, '0, 0, '0);
    check("bypass_count", 32'(bus.count), 0);
`else
    check("nobypass_valid", 32'(bus.instr_valid), 0);
    cyc(1'b1, 1'b0, '0, 0, '0);
    check("nobypass_next_valid", 32'(bus.instr_valid), 1);
    check("nobypass_next_instr", 32'(bus.instr), 32'h2E);
`endif

    // random traffic
    for (int r = 0; r < 400; r++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
          16'($urandom_range(0, 65535)), ($urandom_range(0, 2) != 0) ? 1 : 0, '0);
    end

    // drain what is left
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      cyc(1'b1, 1'b0, '0, 0, '0);
      guard++;
    end
    check("final_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue_ctrl.md
Name: fetch_queue_ctrl

Overview:
- Instruction-fetch front end of the bf8b core.
- Reads instruction bytes from instruction memory using a req/ack handshake.
- Pushes the bytes into the external word-enabled shift register (en_shift_reg, LENGTH=DEPTH, WIDTH=WIDTH) by driving its per-word enables and D input.
- Presents the oldest queued byte to the decoder with a valid/ready handshake.
- Handles PC redirect (loop jumps) by flushing the queue and discarding any in-flight fetch.

Parameters:
- DEPTH, 8: queue depth in words; must match the shift register LENGTH.
- WIDTH, 8: instruction word width.
- ADDR_W, 16: instruction address width.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_req  out  1  fetch request; held until mem_ack
- mem_addr  out  ADDR_W  fetch address; stable while mem_req is high
- mem_ack  in  1  read data valid; may assert in the first cycle of mem_req
- mem_rdata  in  WIDTH  fetched byte; valid with mem_ack
- sr_en  out  DEPTH  per-word shift enables, index 0 = entry word
- sr_d  out  WIDTH  shift register D input (= mem_rdata)
- sr_q_packed  in  DEPTH*WIDTH  shift register contents; word i at [WIDTH*i +: WIDTH]
- instr  out  WIDTH  oldest queued instruction
- instr_valid  out  1  instr is valid
- instr_ready  in  1  decoder consumes instr this cycle
- redirect  in  1  flush queue and load new PC
- redirect_pc  in  ADDR_W  new PC
- count  out  $clog2(DEPTH+1)  occupied words

Behaviour:
- Reset values:
  - pc = RESET_PC, count = 0, state = IDLE.
  - mem_req = 0, instr_valid = 0, sr_en = 0.
  - Shift register contents at reset are don't-care.
- Events per cycle:
  - push = mem_ack && state==WAIT && !redirect.
  - pop = instr_valid && instr_ready && !redirect.
- Queue output:
  - Word 0 is newest; word count-1 is oldest.
  - instr = word count-1 of sr_q_packed.
  - instr_valid = (count != 0). Combinational from registered count.
- Enable generation (combinational):
  - push && !pop: sr_en[i] = (i <= count); count+1.
  - push && pop: sr_en[i] = (i < count); count unchanged (oldest overwritten).
  - pop only: sr_en = 0; count-1.
  - Neither, or redirect: sr_en = 0.
- FSM states: IDLE, WAIT, DROP. mem_req = (state != IDLE). mem_addr = pc.
- IDLE:
  - If !redirect && count < DEPTH, go to WAIT.
- WAIT:
  - On push: pc+1 (wraps modulo 2^ADDR_W). Go to WAIT if next count < DEPTH, else IDLE.
  - Back-to-back fetches sustain 1 byte/cycle with a zero-wait-state memory.
- DROP:
  - Hold mem_req and mem_addr stable until mem_ack.
  - Discard the returning data; go to IDLE.
- Redirect (highest priority):
  - count <= 0, pc <= redirect_pc, sr_en = 0; instr_ready is ignored that cycle.
  - WAIT without ack goes to DROP.
  - WAIT with ack in the same cycle discards the data and goes to IDLE.
  - DROP stays in DROP.
  - IDLE stays in IDLE.
- Latency:
  - Data acked at edge N gives instr_valid at N+1.
  - Redirect at edge N gives the first new mem_req at N+1 (from IDLE), or after the pending ack (from WAIT/DROP).
- Full:
  - No request is issued while count == DEPTH.
  - Push into a full queue cannot occur; the bench asserts this.
- Reset mid-fetch:
  - The FSM returns to IDLE immediately.
  - Memory is required to abort the request on the same rst.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0, state == WAIT, mem_ack, instr_ready and !redirect:
  - instr = mem_rdata, instr_valid = 1 in the same cycle.
  - No push; count stays 0; sr_en = 0; pc+1.
  - Saves one cycle of fetch-to-decode latency when the queue is empty.
- Undefined: the data is always pushed, and instr_valid follows one cycle later.

Decomposition:
- Package fetch_pkg:
  - state enum (IDLE, WAIT, DROP).
  - default DEPTH, WIDTH, ADDR_W constants.
  - count-width function.
- One sub-module, queue_en_decode: combinational.
  - Inputs: count, push, pop.
  - Outputs: sr_en and the oldest-word select.
- The shift register itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then zero-wait memory returning 0x2B,0x2D,0x3E at addresses 0,1,2, instr_ready=1 -> instr sequence 0x2B,0x2D,0x3E on consecutive cycles; mem_addr increments 0,1,2.
- instr_ready=0, memory always acks -> 8 pushes, count=8, mem_req drops; raise ready -> bytes pop oldest-first and fetching resumes at count=7.
- Simultaneous push and pop with count=3 -> sr_en=0b111 (words 0-2), count stays 3, oldest output correct.
- Redirect to 0x0040 while in WAIT, with ack 2 cycles later carrying 0x5B -> 0x5B discarded, count=0, next mem_addr=0x0040.
- Redirect in the same cycle as mem_ack -> data not pushed, count=0, next request at redirect_pc.
- With FETCH_QUEUE_BYPASS_EN, empty queue, ack 0x2E with ready=1 -> instr_valid=1 and instr=0x2E in the ack cycle, count stays 0.
